reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, meaning the first register index dumped.
REQ-002 The block SHALL have parameter LAST_REG, default 31, meaning the last register index dumped (FIRST_REG <= LAST_REG <= 31).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, a one-cycle dump request.
REQ-006 The block SHALL have port reg_sel, output, 5, the register index driven to the register file debug read port.
REQ-007 The block SHALL have port reg_data, input, 32, the combinational register file debug read data for reg_sel.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data/out_idx hold a dumped word.
REQ-009 The block SHALL have port out_ready, input, 1, the consumer accept strobe.
REQ-010 The block SHALL have port out_data, output, 32, the captured register value.
REQ-011 The block SHALL have port out_idx, output, 5, the register index of out_data.
REQ-012 The block SHALL have port busy, output, 1, high from accepted start until DONE exits.
REQ-013 The block SHALL have port done, output, 1, a one-cycle end-of-dump pulse.
REQ-014 The block SHALL have port checksum, output, 32, the XOR of all words transferred in the current or last dump.

Function
REQ-015 The FSM SHALL have states IDLE, SEL, CAP, SEND, DONE.
REQ-016 In IDLE, start=1 SHALL load idx=FIRST_REG, clear checksum to 0, set busy=1 and go to SEL; start outside IDLE SHALL be ignored.
REQ-017 reg_sel SHALL equal the registered idx in every state, and 0 in IDLE.
REQ-018 SEL SHALL last exactly one cycle (read settle) then go to CAP.
REQ-019 CAP SHALL register out_data<=reg_data and out_idx<=idx, then go to SEND.
REQ-020 In SEND, out_valid SHALL be 1, and out_data/out_idx SHALL stay stable until out_valid&&out_ready.
REQ-021 On a SEND handshake, checksum SHALL update to checksum^out_data; if idx==LAST_REG go to DONE, else idx<=idx+1 and go to SEL.
REQ-022 out_valid SHALL be 0 in all states except SEND; out_ready while out_valid=0 SHALL have no effect.
REQ-023 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-024 Per-register latency SHALL be 3 cycles (SEL, CAP, first SEND cycle) with out_ready held high.
REQ-025 idx SHALL never wrap; LAST_REG=31 SHALL terminate without incrementing past 31.
REQ-026 checksum SHALL hold its final value after DONE until the next accepted start.
REQ-027 A register index 0 dump SHALL report whatever reg_data returns (0 from the register file).

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, idx=FIRST_REG, reg_sel=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0, checksum=0, including mid-dump.
REQ-029 After rst release, no transfer SHALL occur until a new start.

Configuration
REQ-030 Macro REG_DUMP_SKIPZERO_EN SHALL, when defined, make CAP skip the word when reg_data==0: no SEND, checksum unchanged, next SEL (or DONE if idx==LAST_REG).
REQ-031 Without REG_DUMP_SKIPZERO_EN every index FIRST_REG..LAST_REG SHALL be transferred, zero or not.

Verification
REQ-032 Default params, rf[i]=i*0x11111111 mod 2^32, out_ready=1, start pulse -> 32 transfers idx 0..31 in order, each 3 cycles apart, done pulse once, checksum = XOR of all values.
REQ-033 out_ready low 5 cycles during SEND of idx 4 (value 0x44444444) -> out_valid stays 1, out_data stable at 0x44444444, idx 5 not selected until handshake.
REQ-034 start pulsed again mid-dump at idx 10 -> ignored, dump completes normally with 32 transfers.
REQ-035 rst asserted asynchronously during SEND of idx 7 -> all outputs 0 same cycle, state IDLE, no further transfers without start.
REQ-036 FIRST_REG=30, LAST_REG=31, rf[30]=0xDEADBEEF, rf[31]=0x12345678 -> two transfers, checksum 0xCC99E897, done once.
REQ-037 REG_DUMP_SKIPZERO_EN defined, only rf[3]=0xA5A5A5A5 nonzero -> exactly one transfer (out_idx=3), checksum 0xA5A5A5A5, done pulse.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader -- walks register indices FIRST_REG..LAST_REG over a
// combinational register-file debug read port. Each captured word is offered
// on a valid/ready output, and a running XOR checksum of the transferred words
// is kept.
//
// Optional build macro:
//   REG_DUMP_SKIPZERO_EN - when defined, words that read as zero are dropped
//                          in CAP. They get no SEND and leave the checksum
//                          unchanged.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle dump request (honoured only when idle)
//   reg_sel    register index driven to the debug read port (0 when idle)
//   reg_data   debug read data for reg_sel (combinational)
//   out_valid  out_data/out_idx hold a dumped word
//   out_ready  consumer accept strobe
//   out_data   captured register value
//   out_idx    register index of out_data
//   busy       high from accepted start until DONE exits
//   done       one-cycle end-of-dump pulse
//   checksum   XOR of all words transferred in the current or last dump
module reg_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {IDLE, SEL, CAP, SEND, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic        last_idx;
    logic        skip_word;

    assign last_idx = (idx == LAST_IDX);

`ifdef REG_DUMP_SKIPZERO_EN
    assign skip_word = (reg_data == '0);
`else
    assign skip_word = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SEL;
            SEL:  state_nxt = CAP;
            CAP: begin
                if (skip_word) begin
                    state_nxt = last_idx ? DONE : SEL;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: if (out_ready) state_nxt = last_idx ? DONE : SEL;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: index walk, capture and checksum accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= FIRST_IDX;
            out_data <= '0;
            out_idx  <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= FIRST_IDX;
                        checksum <= '0;
                    end
                end
                CAP: begin
                    if (!skip_word) begin
                        out_data <= reg_data;
                        out_idx  <= idx;
                    end else if (!last_idx) begin
                        idx <= idx + 5'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        checksum <= checksum ^ out_data;
                        // Stop at LAST_REG so the index never wraps past 31.
                        if (!last_idx) idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        reg_sel   = (state == IDLE) ? '0 : idx;
        out_valid = (state == SEND);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

`ifdef REG_DUMP_SKIPZERO_EN
    localparam bit SKIPZERO = 1'b1;
`else
    localparam bit SKIPZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, rdy0 = 1'b1;
    logic [4:0]  sel0, oidx0;
    logic [31:0] rdata0, data0, cks0;
    logic        v0, busy0, done0;

    logic        start1 = 1'b0, rdy1 = 1'b1;
    logic [4:0]  sel1, oidx1;
    logic [31:0] rdata1, data1, cks1;
    logic        v1, busy1, done1;

    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    assign rdata0 = rf0[sel0];
    assign rdata1 = rf1[sel1];

    reg_dump_reader u0 (
        .clk(clk), .rst(rst), .start(start0), .reg_sel(sel0), .reg_data(rdata0),
        .out_valid(v0), .out_ready(rdy0), .out_data(data0), .out_idx(oidx0),
        .busy(busy0), .done(done0), .checksum(cks0)
    );

    reg_dump_reader #(.FIRST_REG(30), .LAST_REG(31)) u1 (
        .clk(clk), .rst(rst), .start(start1), .reg_sel(sel1), .reg_data(rdata1),
        .out_valid(v1), .out_ready(rdy1), .out_data(data1), .out_idx(oidx1),
        .busy(busy1), .done(done1), .checksum(cks1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed transfers (valid && ready sampled mid-cycle) and done pulses
    logic [4:0]  q0_idx[$];
    logic [31:0] q0_data[$];
    int          q0_cyc[$];
    int          ndone0 = 0;
    logic [4:0]  q1_idx[$];
    logic [31:0] q1_data[$];
    int          ndone1 = 0;

    always @(negedge clk) begin
        if (v0 && rdy0) begin
            q0_idx.push_back(oidx0);
            q0_data.push_back(data0);
            q0_cyc.push_back(cyc);
        end
        if (done0) ndone0 = ndone0 + 1;
        if (v1 && rdy1) begin
            q1_idx.push_back(oidx1);
            q1_data.push_back(data1);
        end
        if (done1) ndone1 = ndone1 + 1;
    end

    // Reference model: which indices get transferred, their values, checksum,
    // and with out_ready held high the cycle offset of each transfer from the
    // first SEL cycle (3 cycles per transferred register, 2 per skipped one).
    logic [4:0]  exp_idx[$];
    logic [31:0] exp_data[$];
    int          exp_off[$];
    logic [31:0] exp_cks;

    task automatic build_model();
        int t = 0;
        exp_idx.delete();
        exp_data.delete();
        exp_off.delete();
        exp_cks = '0;
        for (int i = 0; i < 32; i++) begin
            if (SKIPZERO && rf0[i] == 32'd0) begin
                t += 2;
            end else begin
                exp_idx.push_back(5'(i));
                exp_data.push_back(rf0[i]);
                exp_off.push_back(t + 2);
                exp_cks ^= rf0[i];
                t += 3;
            end
        end
    endtask

    int b0;
    int done_base0;

    task automatic start_dump0(output int s);
        @(posedge clk); #1;
        b0 = q0_idx.size();
        done_base0 = ndone0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        s = cyc;
    endtask

    task automatic wait_dump0(input bit rand_ready, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (rand_ready) rdy0 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (ndone0 > done_base0 && !busy0) begin
                ok = 1'b1;
                break;
            end
        end
        rdy0 = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel0, v0, data0, oidx0, busy0, done0, cks0} !== '0) begin
            failures++;
            $display("FAIL reset_u0 got sel=%0d v=%b data=%h idx=%0d busy=%b done=%b cks=%h exp all 0",
                     sel0, v0, data0, oidx0, busy0, done0, cks0);
        end
        checks++;
        if ({sel1, v1, data1, oidx1, busy1, done1, cks1} !== '0) begin
            failures++;
            $display("FAIL reset_u1 got sel=%0d v=%b data=%h idx=%0d busy=%b done=%b cks=%h exp all 0",
                     sel1, v1, data1, oidx1, busy1, done1, cks1);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({v0, busy0, sel0, v1, busy1} !== '0 || q0_idx.size() != 0) begin
            failures++;
            $display("FAIL reset_idle got v0=%b busy0=%b sel0=%0d v1=%b busy1=%b xfers=%0d exp 0",
                     v0, busy0, sel0, v1, busy1, q0_idx.size());
        end
    endtask

    task automatic test_full_dump();
        int s, n;
        bit ok;
        for (int i = 0; i < 32; i++) rf0[i] = 32'(i) * 32'h1111_1111;
        build_model();
        start_dump0(s);
        checks++;
        if (busy0 !== 1'b1 || sel0 !== 5'd0) begin
            failures++;
            $display("FAIL full_start got busy=%b sel=%0d exp busy=1 sel=0", busy0, sel0);
        end
        wait_dump0(1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_timeout got no done exp done"); end
        n = q0_idx.size() - b0;
        checks++;
        if (n != exp_idx.size()) begin
            failures++;
            $display("FAIL full_count got=%0d exp=%0d", n, exp_idx.size());
        end
        for (int k = 0; k < n && k < exp_idx.size(); k++) begin
            checks++;
            if (q0_idx[b0+k] !== exp_idx[k] || q0_data[b0+k] !== exp_data[k]
                || (q0_cyc[b0+k] - s) != exp_off[k]) begin
                failures++;
                $display("FAIL full_xfer[%0d] got idx=%0d data=%h off=%0d exp idx=%0d data=%h off=%0d",
                         k, q0_idx[b0+k], q0_data[b0+k], q0_cyc[b0+k] - s,
                         exp_idx[k], exp_data[k], exp_off[k]);
            end
        end
        checks++;
        if (ndone0 - done_base0 != 1) begin
            failures++;
            $display("FAIL full_done got=%0d exp=1", ndone0 - done_base0);
        end
        checks++;
        if (cks0 !== exp_cks) begin
            failures++;
            $display("FAIL full_checksum got=%h exp=%h", cks0, exp_cks);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cks0 !== exp_cks || sel0 !== 5'd0 || busy0 !== 1'b0 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL full_hold got cks=%h sel=%0d busy=%b v=%b exp cks=%h sel=0 busy=0 v=0",
                     cks0, sel0, busy0, v0, exp_cks);
        end
    endtask

    task automatic test_backpressure();
        int s, n;
        bit ok, found;
        for (int i = 0; i < 32; i++) rf0[i] = 32'(i) * 32'h1111_1111;
        build_model();
        start_dump0(s);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (v0 && oidx0 == 5'd4) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL bp_reach got no SEND idx4 exp SEND idx4"); end
        rdy0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (v0 !== 1'b1 || data0 !== 32'h4444_4444 || oidx0 !== 5'd4 || sel0 !== 5'd4) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b data=%h idx=%0d sel=%0d exp v=1 data=44444444 idx=4 sel=4",
                         c, v0, data0, oidx0, sel0);
            end
        end
        rdy0 = 1'b1;
        wait_dump0(1'b0, ok);
        n = q0_idx.size() - b0;
        checks++;
        if (!ok || n != exp_idx.size() || cks0 !== exp_cks || ndone0 - done_base0 != 1) begin
            failures++;
            $display("FAIL bp_result got ok=%b n=%0d cks=%h done=%0d exp ok=1 n=%0d cks=%h done=1",
                     ok, n, cks0, ndone0 - done_base0, exp_idx.size(), exp_cks);
        end
        for (int k = 0; k < n && k < exp_idx.size(); k++) begin
            checks++;
            if (q0_idx[b0+k] !== exp_idx[k] || q0_data[b0+k] !== exp_data[k]) begin
                failures++;
                $display("FAIL bp_xfer[%0d] got idx=%0d data=%h exp idx=%0d data=%h",
                         k, q0_idx[b0+k], q0_data[b0+k], exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int s, n;
        bit ok, found;
        for (int i = 0; i < 32; i++) rf0[i] = $urandom | 32'h1;
        build_model();
        start_dump0(s);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (v0 && oidx0 == 5'd10) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_dump0(1'b0, ok);
        n = q0_idx.size() - b0;
        checks++;
        if (!found || !ok || n != exp_idx.size() || cks0 !== exp_cks || ndone0 - done_base0 != 1) begin
            failures++;
            $display("FAIL restart_result got found=%b ok=%b n=%0d cks=%h done=%0d exp n=%0d cks=%h done=1",
                     found, ok, n, cks0, ndone0 - done_base0, exp_idx.size(), exp_cks);
        end
        for (int k = 0; k < n && k < exp_idx.size(); k++) begin
            checks++;
            if (q0_idx[b0+k] !== exp_idx[k] || q0_data[b0+k] !== exp_data[k]) begin
                failures++;
                $display("FAIL restart_xfer[%0d] got idx=%0d data=%h exp idx=%0d data=%h",
                         k, q0_idx[b0+k], q0_data[b0+k], exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_random();
        int s, n;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++)
                rf0[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            build_model();
            start_dump0(s);
            wait_dump0(1'b1, ok);
            n = q0_idx.size() - b0;
            checks++;
            if (!ok || n != exp_idx.size() || cks0 !== exp_cks || ndone0 - done_base0 != 1) begin
                failures++;
                $display("FAIL rand%0d_result got ok=%b n=%0d cks=%h done=%0d exp n=%0d cks=%h done=1",
                         r, ok, n, cks0, ndone0 - done_base0, exp_idx.size(), exp_cks);
            end
            for (int k = 0; k < n && k < exp_idx.size(); k++) begin
                checks++;
                if (q0_idx[b0+k] !== exp_idx[k] || q0_data[b0+k] !== exp_data[k]) begin
                    failures++;
                    $display("FAIL rand%0d_xfer[%0d] got idx=%0d data=%h exp idx=%0d data=%h",
                             r, k, q0_idx[b0+k], q0_data[b0+k], exp_idx[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int s, n;
        bit ok;
        for (int i = 0; i < 32; i++) rf0[i] = 32'd0;
        rf0[3] = 32'hA5A5_A5A5;
        build_model();
        start_dump0(s);
        wait_dump0(1'b0, ok);
        n = q0_idx.size() - b0;
        checks++;
        if (!ok || n != exp_idx.size() || ndone0 - done_base0 != 1) begin
            failures++;
            $display("FAIL sparse_count got ok=%b n=%0d done=%0d exp n=%0d done=1",
                     ok, n, ndone0 - done_base0, exp_idx.size());
        end
        for (int k = 0; k < n && k < exp_idx.size(); k++) begin
            checks++;
            if (q0_idx[b0+k] !== exp_idx[k] || q0_data[b0+k] !== exp_data[k]) begin
                failures++;
                $display("FAIL sparse_xfer[%0d] got idx=%0d data=%h exp idx=%0d data=%h",
                         k, q0_idx[b0+k], q0_data[b0+k], exp_idx[k], exp_data[k]);
            end
        end
        checks++;
        if (cks0 !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL sparse_checksum got=%h exp=a5a5a5a5", cks0);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit found;
        for (int i = 0; i < 32; i++) rf0[i] = 32'(i) * 32'h1111_1111;
        start_dump0(s);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (v0 && oidx0 == 5'd7) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!found || {sel0, v0, data0, oidx0, busy0, done0, cks0} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got found=%b sel=%0d v=%b data=%h idx=%0d busy=%b done=%b cks=%h exp all 0",
                     found, sel0, v0, data0, oidx0, busy0, done0, cks0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        b0 = q0_idx.size();
        done_base0 = ndone0;
        rdy0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (q0_idx.size() != b0 || ndone0 != done_base0 || busy0 !== 1'b0 || sel0 !== 5'd0) begin
            failures++;
            $display("FAIL midrst_quiet got xfers=%0d done=%0d busy=%b sel=%0d exp 0 0 0 0",
                     q0_idx.size() - b0, ndone0 - done_base0, busy0, sel0);
        end
    endtask

    task automatic test_narrow();
        int b1, d1;
        bit ok;
        for (int i = 0; i < 32; i++) rf1[i] = $urandom;
        rf1[30] = 32'hDEAD_BEEF;
        rf1[31] = 32'h1234_5678;
        @(posedge clk); #1;
        b1 = q1_idx.size();
        d1 = ndone1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (ndone1 > d1 && !busy1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || q1_idx.size() - b1 != 2 || ndone1 - d1 != 1) begin
            failures++;
            $display("FAIL narrow_count got ok=%b n=%0d done=%0d exp n=2 done=1",
                     ok, q1_idx.size() - b1, ndone1 - d1);
        end
        if (q1_idx.size() - b1 >= 2) begin
            checks++;
            if (q1_idx[b1] !== 5'd30 || q1_data[b1] !== 32'hDEAD_BEEF
                || q1_idx[b1+1] !== 5'd31 || q1_data[b1+1] !== 32'h1234_5678) begin
                failures++;
                $display("FAIL narrow_xfer got %0d:%h %0d:%h exp 30:deadbeef 31:12345678",
                         q1_idx[b1], q1_data[b1], q1_idx[b1+1], q1_data[b1+1]);
            end
        end
        checks++;
        if (cks1 !== 32'hCC99_E897) begin
            failures++;
            $display("FAIL narrow_checksum got=%h exp=cc99e897", cks1);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf0[i] = 32'd0;
            rf1[i] = 32'd0;
        end
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_random();
        test_sparse();
        test_narrow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
